// File: rtl/pipeline_hazard_scoreboard_pkg.sv
// Shared types and constants for the SimpleRisc hazard scoreboard.
// Entry layout, result-ready stage codes and forward-select encoding.
package pipe_pkg;

  // Widest register index any configuration may use; narrower indices are zero-extended.
  localparam int PKG_AW      = 8;

  // Stage index at which a result becomes forwardable.
  localparam int RDY_ALU     = 2;
  localparam int RDY_LOAD    = 3;

  // Forward-select value meaning "read the register file".
  localparam int SEL_REGFILE = 0;

  typedef struct packed {
    logic              valid;
    logic              wb;
    logic [PKG_AW-1:0] dst;
    logic [2:0]        rdy;
  } entry_t;

  // Ready stages beyond the tracked depth behave as "ready at RW".
  function automatic logic [2:0] sat_rdy(input logic [2:0] r, input int depth);
    if (int'(r) > depth) return 3'(depth);
    return r;
  endfunction

endpackage

// File: rtl/pipeline_hazard_scoreboard_if.sv
// OF-stage request / hazard-control bundle between the pipeline and the scoreboard.
// The pipeline side uses the master modport, the scoreboard the slave modport.
interface pipeline_hazard_scoreboard_if #(
  parameter int REG_AW = 4,
  parameter int SEL_W  = 2
);
  logic              of_valid;
  logic [REG_AW-1:0] of_src1;
  logic [REG_AW-1:0] of_src2;
  logic              of_src1_used;
  logic              of_src2_used;
  logic              of_wb;
  logic [REG_AW-1:0] of_dst;
  logic [2:0]        of_ready_stg;
  logic              ex_hold;
  logic              flush_in;
  logic              stall;
  logic              bubble;
  logic [SEL_W-1:0]  fwd_sel1;
  logic [SEL_W-1:0]  fwd_sel2;
  logic [SEL_W-1:0]  ex_fwd_sel1;
  logic [SEL_W-1:0]  ex_fwd_sel2;

  modport master (
    output of_valid, of_src1, of_src2, of_src1_used, of_src2_used,
           of_wb, of_dst, of_ready_stg, ex_hold, flush_in,
    input  stall, bubble, fwd_sel1, fwd_sel2, ex_fwd_sel1, ex_fwd_sel2
  );

  modport slave (
    input  of_valid, of_src1, of_src2, of_src1_used, of_src2_used,
           of_wb, of_dst, of_ready_stg, ex_hold, flush_in,
    output stall, bubble, fwd_sel1, fwd_sel2, ex_fwd_sel1, ex_fwd_sel2
  );
endinterface

// File: rtl/pipeline_hazard_scoreboard_src_check.sv
// hazard_src_check: per-source producer match, hazard and forward select.
// Optional feature macro: HAZARD_FWD_EN (undefined = no forwarding, wait for RW).
module hazard_src_check
  import pipe_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int REG_AW = 4,
  parameter int SEL_W  = 2
) (
  input  entry_t            ent_i [1:DEPTH],
  input  logic [REG_AW-1:0] src_i,
  input  logic              used_i,
  output logic              hazard_o,
  output logic [SEL_W-1:0]  sel_o
);

  // Youngest matching producer decides; RW producers are covered by write-through.
  always_comb begin
    logic found;
    hazard_o = 1'b0;
    sel_o    = SEL_W'(SEL_REGFILE);
    found    = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      if (!found && used_i && ent_i[i].valid && ent_i[i].wb &&
          ent_i[i].dst == PKG_AW'(src_i)) begin
        found = 1'b1;
        if (i != DEPTH) begin
`ifdef HAZARD_FWD_EN
          // Forward from the stage the producer will occupy next cycle.
          if (int'(ent_i[i].rdy) <= i + 1) sel_o = SEL_W'(i + 1);
          else                             hazard_o = 1'b1;
`else
          hazard_o = 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_scoreboard.sv
// pipeline_hazard_scoreboard: tracks in-flight destination registers after OF
// and drives stall/bubble plus EX operand forward selects.
// Optional feature macro: HAZARD_FWD_EN (forwarding; undefined = interlock to RW).
module pipeline_hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int REG_AW   = 4,
  parameter int DEPTH    = 3,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input logic                      clk,
  input logic                      reset,
  pipeline_hazard_scoreboard_if.slave bus
);

  entry_t           ent_q [1:DEPTH];
  entry_t           ent_d [1:DEPTH];
  logic [SEL_W-1:0] ex_sel1_q, ex_sel1_d;
  logic [SEL_W-1:0] ex_sel2_q, ex_sel2_d;
  logic             haz1, haz2;
  logic [SEL_W-1:0] sel1, sel2;
  logic             hazard;
  logic             issue;
  logic             wb_ok;

  hazard_src_check #(.DEPTH(DEPTH), .REG_AW(REG_AW), .SEL_W(SEL_W)) u_src1 (
    .ent_i    (ent_q),
    .src_i    (bus.of_src1),
    .used_i   (bus.of_src1_used),
    .hazard_o (haz1),
    .sel_o    (sel1)
  );

  hazard_src_check #(.DEPTH(DEPTH), .REG_AW(REG_AW), .SEL_W(SEL_W)) u_src2 (
    .ent_i    (ent_q),
    .src_i    (bus.of_src2),
    .used_i   (bus.of_src2_used),
    .hazard_o (haz2),
    .sel_o    (sel2)
  );

  // Only a real OF instruction can raise a hazard; indices beyond NUM_REGS are never tracked.
  assign hazard = bus.of_valid && (haz1 || haz2);
  assign issue  = bus.of_valid && !hazard && !bus.flush_in;
  assign wb_ok  = bus.of_wb && (int'(bus.of_dst) < NUM_REGS);

  assign bus.stall       = (hazard && !bus.flush_in) || bus.ex_hold;
  assign bus.bubble      = (hazard || bus.flush_in) && !bus.ex_hold;
  assign bus.fwd_sel1    = sel1;
  assign bus.fwd_sel2    = sel2;
  assign bus.ex_fwd_sel1 = ex_sel1_q;
  assign bus.ex_fwd_sel2 = ex_sel2_q;

  // Advance the tracked pipe unless EX holds; insert the issuing instruction at EX.
  always_comb begin
    ent_d     = ent_q;
    ex_sel1_d = ex_sel1_q;
    ex_sel2_d = ex_sel2_q;
    if (!bus.ex_hold) begin
      for (int i = DEPTH; i >= 2; i--) ent_d[i] = ent_q[i-1];
      ent_d[1]  = '0;
      ex_sel1_d = SEL_W'(SEL_REGFILE);
      ex_sel2_d = SEL_W'(SEL_REGFILE);
      if (issue) begin
        ent_d[1].valid = 1'b1;
        ent_d[1].wb    = wb_ok;
        ent_d[1].dst   = PKG_AW'(bus.of_dst);
        ent_d[1].rdy   = sat_rdy(bus.of_ready_stg, DEPTH);
        ex_sel1_d      = sel1;
        ex_sel2_d      = sel2;
      end
    end
  end

  // State register; reset clears entry valid bits and the EX selects only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i <= DEPTH; i++) ent_q[i].valid <= 1'b0;
      ex_sel1_q <= '0;
      ex_sel2_q <= '0;
    end else begin
      ent_q     <= ent_d;
      ex_sel1_q <= ex_sel1_d;
      ex_sel2_q <= ex_sel2_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// Testbench for pipeline_hazard_scoreboard: directed scenarios followed by
// random traffic, checked against a queue-of-producers reference model.
// Follows HAZARD_FWD_EN the same way the design does.
module tb_pipeline_hazard_scoreboard;
  import pipe_pkg::*;

  localparam int DEPTH  = 3;
  localparam int REG_AW = 4;
  localparam int SEL_W  = $clog2(DEPTH + 1);
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_hazard_scoreboard_if #(.REG_AW(REG_AW), .SEL_W(SEL_W)) bus ();

  pipeline_hazard_scoreboard #(
    .NUM_REGS(16), .REG_AW(REG_AW), .DEPTH(DEPTH), .SEL_W(SEL_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: register writers in flight with the stage they occupy (1 = EX).
  typedef struct {
    int dst;
    int rdy;
    int pos;
  } prod_t;

  prod_t inflight[$];
  int    exp_ex1 = 0;
  int    exp_ex2 = 0;
  int    checks  = 0;
  int    passes  = 0;
  int    fails   = 0;
  bit    last_issue;
  logic  obs_stall, obs_bubble;
  logic [SEL_W-1:0] obs_fwd1, obs_fwd2;
  int    w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void lookup(input int s, input bit used, output bit hz, output int sel);
    int best;
    hz   = 1'b0;
    sel  = 0;
    best = -1;
    if (!used) return;
    foreach (inflight[k])
      if (inflight[k].dst == s && (best < 0 || inflight[k].pos < inflight[best].pos)) best = k;
    if (best < 0) return;
    if (inflight[best].pos == DEPTH) return;
    if (FWD && inflight[best].rdy <= inflight[best].pos + 1) sel = inflight[best].pos + 1;
    else hz = 1'b1;
  endfunction

  // One clock: drive OF, check combinational outputs, clock, update model, check EX selects.
  task automatic step(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                      input bit wb, input int dst, input int rdy,
                      input bit hold, input bit flush, input bit rst = 1'b0);
    bit    h1, h2, haz, iss;
    int    e1, e2;
    prod_t nq[$];
    reset            = rst;
    bus.of_valid     = v;
    bus.of_src1      = REG_AW'(s1);
    bus.of_src1_used = u1;
    bus.of_src2      = REG_AW'(s2);
    bus.of_src2_used = u2;
    bus.of_wb        = wb;
    bus.of_dst       = REG_AW'(dst);
    bus.of_ready_stg = 3'(rdy);
    bus.ex_hold      = hold;
    bus.flush_in     = flush;
    lookup(s1, u1, h1, e1);
    lookup(s2, u2, h2, e2);
    haz = v && (h1 || h2);
    iss = v && !haz && !flush;
    #1;
    obs_stall  = bus.stall;
    obs_bubble = bus.bubble;
    obs_fwd1   = bus.fwd_sel1;
    obs_fwd2   = bus.fwd_sel2;
    check("stall",    32'(bus.stall),    32'((haz && !flush) || hold));
    check("bubble",   32'(bus.bubble),   32'((haz || flush) && !hold));
    check("fwd_sel1", 32'(bus.fwd_sel1), 32'(e1));
    check("fwd_sel2", 32'(bus.fwd_sel2), 32'(e2));
    @(posedge clk);
    last_issue = iss && !hold && !rst;
    if (rst) begin
      inflight.delete();
      exp_ex1 = 0;
      exp_ex2 = 0;
    end else if (!hold) begin
      foreach (inflight[k])
        if (inflight[k].pos < DEPTH)
          nq.push_back('{inflight[k].dst, inflight[k].rdy, inflight[k].pos + 1});
      if (iss && wb) nq.push_back('{dst, (rdy > DEPTH) ? DEPTH : rdy, 1});
      inflight = nq;
      exp_ex1  = iss ? e1 : 0;
      exp_ex2  = iss ? e2 : 0;
    end
    #1;
    check("ex_fwd_sel1", 32'(bus.ex_fwd_sel1), 32'(exp_ex1));
    check("ex_fwd_sel2", 32'(bus.ex_fwd_sel2), 32'(exp_ex2));
  endtask

  // Present one instruction until it issues; waits = number of stall cycles.
  task automatic issue(input int s1, input bit u1, input int s2, input bit u2,
                       input bit wb, input int dst, input int rdy, output int waits);
    bit done = 1'b0;
    waits = 0;
    for (int t = 0; t < 8 && !done; t++) begin
      step(1'b1, s1, u1, s2, u2, wb, dst, rdy, 1'b0, 1'b0);
      if (last_issue) done = 1'b1;
      else waits++;
    end
    if (!done) check("issue_bound", 32'(0), 32'(1));
  endtask

  task automatic drain();
    repeat (DEPTH) step(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset and reset values
    step(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0);
    check("rst_stall",  32'(obs_stall),  32'(0));
    check("rst_bubble", 32'(obs_bubble), 32'(0));
    check("rst_ex1",    32'(bus.ex_fwd_sel1), 32'(0));

    // ADD r1,r2,r3 then SUB r2,r1,r3
    issue(2, 1'b1, 3, 1'b1, 1'b1, 1, RDY_ALU, w);
    issue(1, 1'b1, 3, 1'b1, 1'b1, 2, RDY_ALU, w);
    check("alu_waits",  32'(w), FWD ? 32'(0) : 32'(2));
    check("alu_exsel1", 32'(bus.ex_fwd_sel1), FWD ? 32'(2) : 32'(0));
    check("alu_exsel2", 32'(bus.ex_fwd_sel2), 32'(0));
    drain();

    // LD r4 then ADD r5,r4,r4
    issue(0, 1'b0, 0, 1'b0, 1'b1, 4, RDY_LOAD, w);
    issue(4, 1'b1, 4, 1'b1, 1'b1, 5, RDY_ALU, w);
    check("ld_waits",  32'(w), FWD ? 32'(1) : 32'(2));
    check("ld_exsel1", 32'(bus.ex_fwd_sel1), FWD ? 32'(3) : 32'(0));
    check("ld_exsel2", 32'(bus.ex_fwd_sel2), FWD ? 32'(3) : 32'(0));
    drain();

    // MUL r1 then ADD r1, then a consumer of r1: the younger ADD governs
    issue(2, 1'b1, 3, 1'b1, 1'b1, 1, RDY_LOAD, w);
    issue(7, 1'b1, 8, 1'b1, 1'b1, 1, RDY_ALU, w);
    issue(1, 1'b1, 0, 1'b0, 1'b1, 6, RDY_ALU, w);
    check("young_waits", 32'(w), FWD ? 32'(0) : 32'(2));
    check("young_exsel", 32'(bus.ex_fwd_sel1), FWD ? 32'(2) : 32'(0));
    drain();

    // ex_hold for 3 cycles with producers in flight
    issue(0, 1'b0, 0, 1'b0, 1'b1, 4, RDY_LOAD, w);
    issue(11, 1'b1, 12, 1'b1, 1'b1, 9, RDY_ALU, w);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 9, 1'b1, 0, 1'b0, 1'b1, 13, RDY_ALU, 1'b1, 1'b0);
      check("hold_stall",  32'(obs_stall),  32'(1));
      check("hold_bubble", 32'(obs_bubble), 32'(0));
    end
    issue(9, 1'b1, 0, 1'b0, 1'b1, 13, RDY_ALU, w);
    check("hold_waits", 32'(w), FWD ? 32'(0) : 32'(2));
    check("hold_exsel", 32'(bus.ex_fwd_sel1), FWD ? 32'(2) : 32'(0));
    drain();

    // Flush while OF has a hazard: no entry created for the killed instruction
    issue(0, 1'b0, 0, 1'b0, 1'b1, 6, RDY_LOAD, w);
    step(1'b1, 6, 1'b1, 0, 1'b0, 1'b1, 10, RDY_ALU, 1'b0, 1'b1);
    check("flush_stall",  32'(obs_stall),  32'(0));
    check("flush_bubble", 32'(obs_bubble), 32'(1));
    check("flush_exsel",  32'(bus.ex_fwd_sel1), 32'(0));
    step(1'b1, 10, 1'b1, 0, 1'b0, 1'b0, 0, RDY_ALU, 1'b0, 1'b0);
    check("flushed_stall", 32'(obs_stall), 32'(0));
    check("flushed_fwd",   32'(obs_fwd1),  32'(0));
    drain();

    // Ready stage beyond DEPTH saturates to RW
    issue(0, 1'b0, 0, 1'b0, 1'b1, 7, 7, w);
    issue(7, 1'b1, 0, 1'b0, 1'b0, 0, RDY_ALU, w);
    check("sat_waits", 32'(w), FWD ? 32'(1) : 32'(2));
    check("sat_exsel", 32'(bus.ex_fwd_sel1), FWD ? 32'(3) : 32'(0));
    drain();

    // Reset asserted mid-hold clears the tracker
    issue(0, 1'b0, 0, 1'b0, 1'b1, 5, RDY_LOAD, w);
    step(1'b1, 5, 1'b1, 0, 1'b0, 1'b0, 0, RDY_ALU, 1'b1, 1'b0);
    step(1'b1, 5, 1'b1, 0, 1'b0, 1'b0, 0, RDY_ALU, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5, 1'b1, 0, 1'b0, 1'b0, 0, RDY_ALU, 1'b0, 1'b0);
    check("rsthold_stall", 32'(obs_stall), 32'(0));
    check("rsthold_fwd",   32'(obs_fwd1),  32'(0));

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0,
           int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
           $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
           int'($urandom_range(1, 7)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 63) == 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_scoreboard.md
# pipeline_hazard_scoreboard

Parametrised hazard and forwarding controller for the SimpleRisc pipeline. It replaces the fixed-depth `data_interlock` and `forwarding_src1`/`forwarding_src2` logic with one stateful tracker of in-flight destination registers. The tracker supports configurable post-OF depth, per-instruction result-ready stage, multi-cycle EX holds and branch flush. It sits beside the OF stage and drives the IF/OF and OF/EX latch stall and bubble controls plus the EX operand-select muxes.

## Interface
Parameters:
- `NUM_REGS`, 16, architectural register count.
- `REG_AW`, 4, register index width; must satisfy 2^REG_AW >= NUM_REGS.
- `DEPTH`, 3, tracked stages after OF, ordered EX=1, MA=2, RW=DEPTH; range 2..7.
- `SEL_W`, $clog2(DEPTH+1), width of the forward-select field.

Ports:
- `clk`, in, 1, single clock.
- `reset`, in, 1, synchronous, active-high.
- `of_valid`, in, 1, OF holds a real instruction.
- `of_src1`, `of_src2`, in, REG_AW each, source register indices.
- `of_src1_used`, `of_src2_used`, in, 1 each, the source is actually read.
- `of_wb`, in, 1, the instruction writes a register.
- `of_dst`, in, REG_AW, destination index.
- `of_ready_stg`, in, 3, stage index at which the result is forwardable: ALU=2, load=3. Legal range 1..DEPTH; larger values saturate to DEPTH.
- `ex_hold`, in, 1, EX is busy with a multi-cycle op; the whole tracked pipe freezes.
- `flush_in`, in, 1, branch taken in EX; kill the OF instruction.
- `stall`, out, 1, hold PC and IF/OF.
- `bubble`, out, 1, OF/EX latch loads a NOP.
- `fwd_sel1`, `fwd_sel2`, out, SEL_W each, combinational selects for the instruction now leaving OF. 0 = register file; k = result of the stage at index k.
- `ex_fwd_sel1`, `ex_fwd_sel2`, out, SEL_W each, registered copies aligned with the instruction in EX.

## Operation
- State: an entry array `ent[1..DEPTH]`, each entry {valid, wb, dst, rdy}. `ent[1]` is the EX occupant.
- Match: for source s, a match is the lowest index i whose entry has valid && wb && dst==s. The youngest producer wins.
- Hazard, per used source with a match at index i:
  - If i == DEPTH: no hazard, select 0. The register file writes in RW with write-through.
  - Else if rdy <= i+1: no hazard, select i+1, the stage the producer occupies next cycle.
  - Else: hazard.
- `stall` = of_valid && any hazard && !flush_in, OR ex_hold.
- `bubble` = (hazard || flush_in) && !ex_hold.
- Update each cycle, in priority order:
  1. reset: all entries invalid; ex_fwd_sel* = 0.
  2. ex_hold: no shift; all state held.
  3. Otherwise shift: `ent[i+1] <= ent[i]` and the `ent[DEPTH]` occupant retires. Then `ent[1] <=` the OF instruction if of_valid && !hazard && !flush_in, else an invalid entry. ex_fwd_sel* load fwd_sel* when the instruction is issued, else 0.
- `flush_in` is sampled only when ex_hold=0. The EX branch unit holds it high for as long as EX is held.
- An unused source never causes a hazard, and its select is 0.

## Timing
- Reset values: stall=0, bubble=0, fwd_sel*=0, ex_fwd_sel*=0, all entries invalid.
- stall, bubble and fwd_sel* are combinational from inputs and current state, with zero-cycle latency. ex_fwd_sel* is valid one cycle after issue.
- An ALU producer followed by a dependent consumer issues back-to-back with select 2 (MA) and no stall.
- A load producer followed by a dependent consumer incurs one stall cycle, then issues with select 3 (RW).
- Two producers of the same dst in flight: the younger one governs the decision.
- Reset asserted mid-hold or mid-stall clears everything on the next edge.

## Configuration
- `HAZARD_FWD_EN` defined: forwarding as described above.
- `HAZARD_FWD_EN` undefined: any match at i < DEPTH is a hazard, and all selects are forced to 0. Consumers wait until the producer reaches RW.

## Structure
- Shared package `pipe_pkg`:
  - entry typedef;
  - `RDY_ALU`=2 and `RDY_LOAD`=3;
  - the SEL encoding, where 0 = REGFILE.
- One sub-module, `hazard_src_check`, instantiated twice: per-source match, hazard and select logic over the entry array.

## Test plan
- ADD r1 then SUB r2,r1,r3 (ALU rdy=2) -> no stall; fwd_sel1=2; ex_fwd_sel1=2 the following cycle.
- LD r4 then ADD r5,r4,r4 -> stall=1 and bubble=1 for one cycle; next cycle fwd_sel1=fwd_sel2=3; issue.
- MUL r1 then ADD r1, then a consumer of r1 -> the younger ADD governs: select 2, no stall.
- ex_hold=1 for 3 cycles with producers in flight -> stall=1, bubble=0, entries frozen; on release, forwarding resumes with unchanged selects.
- flush_in=1 while OF has a hazard -> stall=0, bubble=1, and no entry is created for the OF instruction.
- Build without `HAZARD_FWD_EN`: ADD r1 then a dependent instruction -> stall for DEPTH-1=2 cycles, then issue with fwd_sel1=0.
